// File: rtl/tdc_result_tx_pkg.sv
// Shared definitions for the TDC result serial transmitter: frame bit
// constants and the transmitter state encoding.
package tdc_result_tx_pkg;

    // Line level driven during the start and stop bit cells.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Transmitter states; a frame walks START -> DATA -> PARITY -> STOP.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage : tdc_result_tx_pkg

// File: rtl/tdc_result_tx_fifo.sv
// Small synchronous FIFO buffering measurement results between capture and
// the serial transmitter. DEPTH must be a power of two so the pointers wrap
// naturally.
//
// Handshake: a push is accepted when the FIFO is not full, or when a pop
// happens on the same edge (the slot being read frees up). A pop is only
// honoured when the FIFO is non-empty. rd_data always shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             wr_en;
    logic             rd_en;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Next pointer and occupancy values; level moves only when exactly one side acts.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : sync_fifo

// File: rtl/tdc_result_tx.sv
// TDC result transmitter: captures the pulse counter result on each rising
// edge of ready, buffers it, and sends it on a UART-like line as
// start(0), WIDTH data bits LSB first, even parity, stop(1).
module tdc_result_tx
    import tdc_result_tx_pkg::*;
#(
    parameter int WIDTH        = 7,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_overflow,
    output logic             tx,
    output logic             busy,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level,
    output tx_state_e        state_dbg
);

    localparam int              BIT_W    = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]      CPB_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q,   par_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             ready_q;
    logic             overflow_q, overflow_d;

    logic             capture;
    logic             last_cell;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;

    // A capture is the first cycle ready is seen high; ready_q resets high so
    // a ready already asserted at reset release is not mistaken for an edge.
    assign capture   = ready && !ready_q;
    assign last_cell = (cnt_q == CPB_LAST);

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (capture),
        .wr_data (count_in),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Sticky overflow: a dropped capture sets it and beats a coincident clear.
    always_comb begin
        overflow_d = overflow_q;
        if (capture && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Frame sequencer: bit-cell timing, data shifting and the registered line value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        tx_d     = STOP_BIT;
        busy_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    par_d    = ^fifo_rd_data;
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (last_cell) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (last_cell) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PARITY: begin
                if (last_cell) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STOP: begin
                if (last_cell) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Line value is derived from the upcoming state so tx leaves a flop
        // aligned with the state it belongs to.
        case (state_d)
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = STOP_BIT;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, shifter, line and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= STOP_BIT;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready;
            overflow_q <= overflow_d;
        end
    end

endmodule : tdc_result_tx

// File: tb/tb_tdc_result_tx.sv
// Directed bench for tdc_result_tx with WIDTH=7, CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_tdc_result_tx;
    import tdc_result_tx_pkg::*;

    localparam int W    = 7;
    localparam int CPB  = 4;
    localparam int DEP  = 4;
    localparam int FCYC = (W + 3) * CPB;

    logic         clk;
    logic         rst;
    logic         ready;
    logic [W-1:0] count_in;
    logic         clr_overflow;
    logic         tx;
    logic         busy;
    logic         overflow;
    logic [2:0]   fifo_level;
    tx_state_e    state_dbg;

    int checks = 0;
    int errors = 0;
    int frame_starts = 0;
    logic busy_prev = 1'b0;

    tdc_result_tx #(
        .WIDTH        (W),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .count_in     (count_in),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Counts frame starts (busy rising) for the no-extra-frame checks
    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev !== 1'b1) frame_starts++;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected 10-bit frame, bit 0 is the first cell on the line
    function automatic logic [9:0] exp_frame(input logic [W-1:0] v);
        return {1'b1, ^v, v, 1'b0};
    endfunction

    // One ready pulse: high for one cycle, low for one cycle
    task automatic pulse(input logic [W-1:0] v, input logic c);
        @(posedge clk); #1;
        ready = 1'b1;
        count_in = v;
        clr_overflow = c;
        @(posedge clk); #1;
        ready = 1'b0;
        clr_overflow = 1'b0;
    endtask

    // Waits for a frame, samples every cycle of it at the negedge
    task automatic get_frame(output logic [9:0] bits, output int blen, output int glitches);
        int t;
        bits = '0;
        blen = 0;
        glitches = 0;
        t = 0;
        while (busy !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b1) return;
        for (int c = 0; c < FCYC; c++) begin
            if (c % CPB == 0) bits[c / CPB] = tx;
            else if (tx !== bits[c / CPB]) glitches++;
            if (busy === 1'b1) blen++;
            @(negedge clk);
        end
        t = 0;
        while (busy === 1'b1 && t < 200) begin
            blen++;
            t++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [9:0] bits;
        int blen;
        int gl;
        int base;
        int peak;

        rst = 1'b1;
        ready = 1'b0;
        count_in = '0;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 0x55: line 0,1,0,1,0,1,0,1,0,1 with a 40-cycle busy
        pulse(7'h55, 1'b0);
        chk("h55_level_after_push", 32'(fifo_level), 32'd1);
        get_frame(bits, blen, gl);
        chk("h55_frame", 32'(bits), 32'h2AA);
        chk("h55_busy_len", 32'(blen), 32'd40);
        chk("h55_glitch", 32'(gl), 32'd0);
        chk("h55_idle_tx", 32'(tx), 32'd1);

        // 100: data 0,0,1,0,0,1,1 then parity 1
        pulse(7'd100, 1'b0);
        get_frame(bits, blen, gl);
        chk("d100_frame", 32'(bits), 32'h3C8);
        chk("d100_glitch", 32'(gl), 32'd0);

        // Six pulses 2 cycles apart: 1..5 sent, 6 dropped
        base = frame_starts;
        peak = 0;
        fork
            begin
                for (int v = 1; v <= 6; v++) pulse(W'(v), 1'b0);
            end
            begin
                for (int i = 1; i <= 5; i++) begin
                    logic [9:0] fb;
                    int fl;
                    int fg;
                    get_frame(fb, fl, fg);
                    chk($sformatf("burst_frame%0d", i), 32'(fb), 32'(exp_frame(W'(i))));
                    chk($sformatf("burst_len%0d", i), 32'(fl), 32'd40);
                end
            end
            begin
                repeat (300) begin
                    @(negedge clk);
                    if (int'(fifo_level) > peak) peak = int'(fifo_level);
                end
            end
        join
        chk("burst_frames", 32'(frame_starts - base), 32'd5);
        chk("burst_overflow", 32'(overflow), 32'd1);
        chk("burst_peak_level", 32'(peak), 32'd4);
        chk("burst_level_end", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Ready held for 100 cycles gives one frame only
        base = frame_starts;
        @(posedge clk); #1;
        ready = 1'b1;
        count_in = 7'h2A;
        repeat (100) @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (60) @(negedge clk);
        chk("held_ready_frames", 32'(frame_starts - base), 32'd1);

        // Reset in the middle of a frame with a second word queued
        pulse(7'h0A, 1'b0);
        pulse(7'h33, 1'b0);
        begin
            int t;
            t = 0;
            while (busy !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        repeat (3 * CPB) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_level", 32'(fifo_level), 32'd1);
        ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_level", 32'(fifo_level), 32'd0);
        chk("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        base = frame_starts;
        repeat (100) @(negedge clk);
        chk("post_rst_frames", 32'(frame_starts - base), 32'd0);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (2) @(posedge clk);

        // Clear coinciding with an overflowing capture: set wins
        for (int v = 1; v <= 5; v++) pulse(W'(v), 1'b0);
        chk("fill_level", 32'(fifo_level), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd0);
        pulse(7'h66, 1'b1);
        chk("set_wins_ovf", 32'(overflow), 32'd1);
        chk("drop_level", 32'(fifo_level), 32'd4);
        @(posedge clk); #1;
        clr_overflow = 1'b1;
        @(posedge clk); #1;
        clr_overflow = 1'b0;
        chk("late_clear_ovf", 32'(overflow), 32'd0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tdc_result_tx

// File: doc/tdc_result_tx.md
TDC_RESULT_TX -- requirements
Module: tdc_result_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, meaning the result word width (matches the pulse counter count_out).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit; legal range 1..255.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning result buffer entries; power of two only.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port ready, input, 1 bit, the measurement-done flag from the controller.
REQ-007 The block SHALL have port count_in, input, WIDTH bits, the measurement result from the pulse counter.
REQ-008 The block SHALL have port clr_overflow, input, 1 bit, a synchronous clear of the overflow flag.
REQ-009 The block SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is on tx.
REQ-011 The block SHALL have port overflow, output, 1 bit, a sticky flag indicating a result was dropped.
REQ-012 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits, the number of stored results (0..FIFO_DEPTH).

Function
REQ-013 Capture SHALL occur on the clk edge where ready=1 and the registered ready_q=0 (rising edge); count_in sampled on that edge is pushed.
REQ-014 Level ready SHALL produce exactly one capture per rising edge; a held ready SHALL NOT produce repeat captures.
REQ-015 Capture with FIFO full and no pop on the same edge SHALL drop the word and set overflow; FIFO contents SHALL be unchanged.
REQ-016 Capture with FIFO full and a pop on the same edge SHALL be accepted; the level SHALL stay at FIFO_DEPTH.
REQ-017 overflow SHALL hold until clr_overflow=1; if set and clear coincide, set SHALL win.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE, tx=1; when the FIFO is non-empty, the FSM SHALL pop the head into a shift register and go to START on the next edge.
REQ-020 START, PARITY and STOP SHALL each last CLKS_PER_BIT cycles; DATA SHALL last WIDTH*CLKS_PER_BIT cycles.
REQ-021 The tx line SHALL carry, per state: START=0; DATA=WIDTH bits LSB first; PARITY=even parity (XOR of data bits); STOP=1.
REQ-022 After STOP the FSM SHALL return to IDLE; frame-to-frame spacing SHALL be (WIDTH+3)*CLKS_PER_BIT+1 cycles.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 tx SHALL be driven from a register (glitch-free).
REQ-025 With CLKS_PER_BIT=1, each bit SHALL last exactly one cycle.
REQ-026 fifo_level SHALL update on the same edge as the push or pop.

Reset
REQ-027 On rst=1, the block SHALL immediately force tx=1, busy=0, overflow=0, fifo_level=0 and state=IDLE, and clear the bit and cycle counters.
REQ-028 ready_q SHALL reset to 1, so that ready already high at reset release causes no capture.
REQ-029 Reset mid-frame SHALL abort the frame and discard the FIFO; the first post-reset frame SHALL start only after a new ready rising edge.

Structure
REQ-030 The frame constants (START_BIT=0, STOP_BIT=1) and the state encoding SHALL live in the shared logic include file.
REQ-031 The buffer SHALL be one sub-module, sync_fifo (WIDTH, DEPTH; push, pop, full, empty, level).
REQ-032 The FSM, edge capture and shifter SHALL reside in tdc_result_tx.

Verification
REQ-033 With count_in=7'h55, a ready pulse, and CLKS_PER_BIT=4, the bench SHALL check tx=0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles, and a 40-cycle busy.
REQ-034 With count_in=7'd100, the bench SHALL check data bits 0,0,1,0,0,1,1 followed by parity bit 1.
REQ-035 With 6 ready pulses 2 cycles apart (values 1..6) while idle, the bench SHALL check frames 1,2,3,4,5 transmitted, 6 dropped, overflow=1 and peak fifo_level=4.
REQ-036 Holding ready high for 100 cycles SHALL produce exactly one frame.
REQ-037 Asserting rst at frame bit 3 SHALL force tx=1, busy=0 and fifo_level=0 at once; with ready held high through reset release, no frame SHALL follow.
REQ-038 Asserting clr_overflow on the same cycle as an overflowing capture SHALL leave overflow=1; clr_overflow one cycle later SHALL clear it to 0.
